// File: rtl/sr_pkg.sv
// Shared constants and next-state function for the SR flip-flop bank.
package sr_pkg;

  localparam int CONF_HOLD   = 0;
  localparam int CONF_SET    = 1;
  localparam int CONF_RST    = 2;
  localparam int CONF_TOGGLE = 3;

  function automatic logic sr_next(
    input logic       q,
    input logic       s,
    input logic       r,
    input logic [1:0] mode
  );
    logic w_n;
    w_n = q;
    case ({s, r})
      2'b10: w_n = 1'b1;
      2'b01: w_n = 1'b0;
      2'b11: begin
        case (mode)
          2'(CONF_SET):    w_n = 1'b1;
          2'(CONF_RST):    w_n = 1'b0;
          2'(CONF_TOGGLE): w_n = ~q;
          default:         w_n = q;
        endcase
      end
      default: w_n = q;
    endcase
    return w_n;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR channel: state bit plus registered rise/fall pulses.
module sr_ff_cell
  import sr_pkg::*;
#(
  parameter int MODE = CONF_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam logic [1:0] M = 2'(MODE);

  logic r_q;
  logic r_rise;
  logic r_fall;
  logic w_d;

  assign w_d = sr_next(r_q, s, r, M);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (en) begin
      r_q    <= w_d;
      r_rise <= ~r_q & w_d;
      r_fall <= r_q & ~w_d;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of SR flip-flops with selectable S=R=1 policy and a conflict monitor.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int CONFLICT_MODE = CONF_HOLD,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_mon,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             conflict_flag,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
    $error("sr_ff_bank: CONFLICT_MODE must be 0..3");
  end
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_width
    $error("sr_ff_bank: WIDTH and CNT_W must be >= 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             w_conf;
  logic             r_flag;
  logic [CNT_W-1:0] r_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(
      .MODE(CONFLICT_MODE)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign w_conf = en & (|(s & r));

  // A new conflict outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag <= 1'b0;
      r_cnt  <= '0;
    end else if (w_conf) begin
      r_flag <= 1'b1;
      if (clr_mon)
        r_cnt <= CNT_ONE;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CNT_ONE;
    end else if (clr_mon) begin
      r_flag <= 1'b0;
      r_cnt  <= '0;
    end
  end

  assign qbar          = ~q;
  assign conflict_flag = r_flag;
  assign conflict_cnt  = r_cnt;

endmodule
